fpu_div_ctrl: RTL and testbench
===============================

Name: fpu_div_ctrl

Overview:
- Initiator/controller for the iterative fraction divider core (start/busy/ready handshake, operands in .1xxx format, quotient in x.xxx format).
- Accepts two IEEE-754 single-precision operands over a valid/ready handshake and unpacks them into divider-format mantissas.
- Handles special cases without the core; otherwise starts the core, waits for ready, then normalises, rounds (round-to-nearest-even) and packs the quotient.
- Sits between the FPU issue logic and the divider core.

Parameters:
- EXP_BIAS, 127, single-precision exponent bias.
- QNAN, 32'h7FC00000, canonical NaN returned for invalid operations.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  high only in IDLE.
- a_fp  input  32  dividend, IEEE-754 single.
- b_fp  input  32  divisor, IEEE-754 single.
- div_a  output  32  to core: {1'b1, a_frac[22:0], 8'b0}.
- div_b  output  32  to core: {1'b1, b_frac[22:0], 8'b0}.
- div_start  output  1  one-cycle start pulse to core.
- div_ready  input  1  core quotient ready.
- div_q  input  32  core quotient, bit 31 = integer bit.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  IEEE-754 quotient.
- flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1; div_start=0; out_valid=0; result=0; flags=0; div_a and div_b=0. Reset mid-operation aborts the operation. The core is not reset by this block; the next div_start reinitialises it.
- Unpack:
  - sign = a[31]^b[31].
  - Exponent field 0 is treated as zero (denormals flushed).
  - Exponent field 255 is inf (frac=0) or NaN (frac!=0).
- States: IDLE, START, WAIT, ROUND, DONE.
- IDLE: on edge with in_valid && in_ready, register operands and the special-case decision.
  - Special case: go to DONE with result/flags loaded; out_valid is high the cycle after acceptance.
  - Normal case: go to START.
- START: div_start=1 for exactly one cycle, with div_a/div_b stable. Next state WAIT.
- WAIT: div_start=0. On the first edge with div_ready=1, capture div_q and go to ROUND. div_busy is not needed; div_ready is not sampled in START.
- ROUND:
  - Compute e = ea - eb + EXP_BIAS in signed 10-bit arithmetic.
  - If q[31]=1: mant=q[31:8], guard=q[7], sticky=|q[6:0].
  - Else: mant=q[30:7], guard=q[6], sticky=|q[5:0], and e=e-1.
  - Round up when guard && (sticky || mant[0]). Mantissa carry-out sets mant=24'h800000 and e=e+1.
  - e>=255 gives inf with overflow=1 and inexact=1.
  - e<=0 gives signed zero with underflow=1 and inexact=1.
  - Otherwise inexact = guard|sticky.
  - Register result and flags, then go to DONE.
- DONE: out_valid=1; result and flags are held stable until out_ready=1 at an edge. Then out_valid=0 and state=IDLE; in_ready rises the next cycle (no same-cycle accept).
- Special cases, in priority order:
  - Either NaN, 0/0, or inf/inf: QNAN, invalid=1.
  - finite/0: signed inf, div_by_zero=1.
  - inf/finite: signed inf, no flags.
  - 0/finite or finite/inf: signed zero, no flags.
- Normal latency: acceptance → START (1) → core iterations → div_ready → ROUND (1) → DONE. out_valid is high 2 cycles after the edge on which div_ready is first sampled high.
- div_start must never assert outside START. At most one core operation is outstanding.

Test Plan:
1. 6.0/3.0 (a=0x40C00000, b=0x40400000) → result=0x40000000, flags=0; exactly one div_start pulse; div_a=0xC0000000, div_b=0xC0000000.
2. 1.0/3.0 (0x3F800000, 0x40400000) → result=0x3EAAAAAB, flags=5'b00001; -1.0/3.0 (0xBF800000) → 0xBEAAAAAB.
3. 1.0/0 (0x3F800000, 0x00000000) → 0x7F800000, div_by_zero=1, no div_start, out_valid the cycle after accept. 0/0 → 0x7FC00000, invalid=1. NaN/2.0 → 0x7FC00000, invalid=1.
4. 2^127/0.25 (0x7F000000, 0x3E800000) → 0x7F800000, overflow=1, inexact=1. 2^-126/4.0 (0x00800000, 0x40800000) → 0x00000000, underflow=1.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid → result/flags stable, in_ready=0, no div_start. Then out_ready=1 → IDLE; in_ready=1 the next cycle.
6. Assert rst during WAIT → all outputs at reset values immediately. Then issue 6.0/3.0 → correct 0x40000000 with a fresh single div_start.

Source files
------------

// File: rtl/fpu_div_ctrl.sv
// fpu_div_ctrl: accepts an IEEE-754 single-precision operand pair, resolves
// special operands locally, otherwise drives the iterative fraction divider
// core and rounds (nearest-even) and packs its x.xxx quotient.
module fpu_div_ctrl #(
  parameter int          EXP_BIAS = 127,
  parameter logic [31:0] QNAN     = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_fp,
  input  logic [31:0] b_fp,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic        div_ready,
  input  logic [31:0] div_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  typedef enum logic [2:0] {IDLE, START, WAIT, ROUND, DONE} state_t;

  localparam logic signed [9:0] BIAS = 10'(EXP_BIAS);

  state_t state, state_nxt;

  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
  logic        special;
  logic [31:0] spec_result;
  logic [4:0]  spec_flags;

  // operands held for the rounding step
  logic        sign_r;
  logic [7:0]  ea_r, eb_r;
  logic [31:0] q_r;

  assign a_exp   = a_fp[30:23];
  assign b_exp   = b_fp[30:23];
  assign a_frac  = a_fp[22:0];
  assign b_frac  = b_fp[22:0];
  assign sign_in = a_fp[31] ^ b_fp[31];
  // exponent field 0 flushes to zero whatever the fraction holds
  assign a_zero  = (a_exp == 8'd0);
  assign b_zero  = (b_exp == 8'd0);
  assign a_inf   = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf   = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan   = (b_exp == 8'hFF) && (b_frac != 23'd0);

  // Normalise the core quotient, round to nearest-even, detect range
  // limits and pack. Returns {flags, result}.
  function automatic logic [36:0] round_pack(input logic        sign,
                                             input logic [7:0]  ea,
                                             input logic [7:0]  eb,
                                             input logic [31:0] q);
    logic signed [9:0] e;
    logic [23:0]       mant;
    logic              guard, sticky, round_up;
    logic [24:0]       mant_inc;
    logic [31:0]       res;
    logic [4:0]        flg;
    e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
    if (q[31]) begin
      mant   = q[31:8];
      guard  = q[7];
      sticky = |q[6:0];
    end else begin
      mant   = q[30:7];
      guard  = q[6];
      sticky = |q[5:0];
      e      = e - 10'sd1;
    end
    round_up = guard & (sticky | mant[0]);
    mant_inc = {1'b0, mant} + {24'd0, round_up};
    if (mant_inc[24]) begin
      mant = 24'h800000;
      e    = e + 10'sd1;
    end else begin
      mant = mant_inc[23:0];
    end
    if (e >= 10'sd255) begin
      res = {sign, 8'hFF, 23'd0};
      flg = 5'b00101;
    end else if (e <= 10'sd0) begin
      res = {sign, 31'd0};
      flg = 5'b00011;
    end else begin
      res = {sign, e[7:0], mant[22:0]};
      flg = {4'b0000, guard | sticky};
    end
    return {flg, res};
  endfunction

  // Special-operand decision, evaluated against the offered operand pair
  always_comb begin
    special     = 1'b1;
    spec_result = '0;
    spec_flags  = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result = QNAN;
      spec_flags  = 5'b10000;
    end else if (b_zero) begin
      spec_result = {sign_in, 8'hFF, 23'd0};
      spec_flags  = 5'b01000;
    end else if (a_inf) begin
      spec_result = {sign_in, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      spec_result = {sign_in, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  // Next-state and handshake outputs decoded from the current state
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = special ? DONE : START;
      end
      START: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (div_ready) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and externally visible data, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      div_a  <= '0;
      div_b  <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // accept: special results go straight out, others feed the core
        IDLE: if (in_valid) begin
          if (special) begin
            result <= spec_result;
            flags  <= spec_flags;
          end else begin
            div_a <= {1'b1, a_frac, 8'd0};
            div_b <= {1'b1, b_frac, 8'd0};
          end
        end
        // round/pack stage: core quotient becomes the IEEE result
        ROUND: {flags, result} <= round_pack(sign_r, ea_r, eb_r, q_r);
        default: ;
      endcase
    end
  end

  // Internal datapath captures; no reset needed, always written before use
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sign_r <= sign_in;
      ea_r   <= a_exp;
      eb_r   <= b_exp;
    end
    if (state == WAIT && div_ready) q_r <= div_q;
  end

endmodule

// File: tb/tb_fpu_div_ctrl.sv
// Bench for fpu_div_ctrl: directed vector table, hand-written backpressure
// and reset sequences, and random operands against an arithmetic model.
module tb_fpu_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_fp = '0;
  logic [31:0] b_fp = '0;
  logic [31:0] div_a, div_b;
  logic        div_start;
  logic        div_ready;
  logic [31:0] div_q;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int last_lat = 0;
  int force_lat = -1;
  logic [31:0] last_div_a = '0;
  logic [31:0] last_div_b = '0;

  fpu_div_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_fp(a_fp), .b_fp(b_fp), .div_a(div_a), .div_b(div_b),
    .div_start(div_start), .div_ready(div_ready), .div_q(div_q),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (div_start === 1'b1) starts <= starts + 1;

  // Divider core stand-in: quotient = A/B with 31 fraction bits after a random delay
  initial begin : core
    int lat;
    bit abort;
    logic [31:0] ca, cb;
    logic [63:0] num;
    div_ready = 1'b0;
    div_q = '0;
    forever begin
      @(posedge clk);
      if (div_start === 1'b1 && !rst) begin
        ca = div_a;
        cb = div_b;
        last_div_a = ca;
        last_div_b = cb;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
        last_lat = lat;
        abort = 0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk);
          if (rst) begin abort = 1; break; end
        end
        if (!abort) begin
          #1;
          num = {32'h0, ca} << 31;
          div_q = 32'(num / {32'h0, cb});
          div_ready = 1'b1;
          @(posedge clk); #1;
          div_ready = 1'b0;
          div_q = $urandom();
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain IEEE-style division with the divider's truncated quotient
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f,
                                  output bit special);
    bit s, az, bz, ai, bi, an, bn;
    int ea, eb, e;
    longint ma, mb, q, m, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    special = 1;
    f = 5'b00000;
    r = '0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r = 32'h7FC00000; f = 5'b10000;
    end else if (bz) begin
      r = {s, 8'hFF, 23'd0}; f = 5'b01000;
    end else if (ai) begin
      r = {s, 8'hFF, 23'd0};
    end else if (az || bi) begin
      r = {s, 31'd0};
    end else begin
      special = 0;
      ma = longint'(a[22:0]) + 64'h800000;
      mb = longint'(b[22:0]) + 64'h800000;
      q  = (ma * 64'h80000000) / mb;
      e  = ea - eb + 127;
      if (q >= 64'h80000000) begin
        m = q / 256; rem = q % 256; half = 128;
      end else begin
        m = q / 128; rem = q % 128; half = 64; e = e - 1;
      end
      if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
      if (m == 64'h1000000) begin m = m / 2; e = e + 1; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; f = 5'b00101;
      end else if (e <= 0) begin
        r = {s, 31'd0}; f = 5'b00011;
      end else begin
        r = {s, 8'(e), 23'(m % 64'h800000)};
        f = {4'b0000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int sel;
    v = $urandom();
    sel = int'($urandom_range(0, 15));
    if (sel == 0) v[30:23] = 8'h00;
    else if (sel == 1) begin v[30:23] = 8'hFF; v[22:0] = '0; end
    else if (sel == 2) begin v[30:23] = 8'hFF; v[0] = 1'b1; end
    else v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  // One full transaction: offer, wait result, optionally stall, then consume
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] r, output logic [4:0] f,
                       output int nstart, output int acc2val, output bit ok);
    int cnt, s0;
    ok = 1; r = '0; f = '0; acc2val = 0; cnt = 0;
    while (!in_ready && cnt < 50) begin @(posedge clk); #1; cnt++; end
    if (!in_ready) ok = 0;
    s0 = starts;
    a_fp = a; b_fp = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_fp = $urandom(); b_fp = $urandom();
    acc2val = 1; cnt = 0;
    while (!out_valid && cnt < 100) begin @(posedge clk); #1; acc2val++; cnt++; end
    if (!out_valid) ok = 0;
    else begin
      r = result; f = flags;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (result !== r || flags !== f || !out_valid) ok = 0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    nstart = starts - s0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
    bit          spec;
  } vec_t;

  vec_t vt[17];

  initial begin : main
    logic [31:0] r, er;
    logic [4:0]  f, ef;
    int ns, acc, s0;
    bit ok, sp;

    vt[0]  = '{32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000, 1'b0};
    vt[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 1'b0};
    vt[2]  = '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'b00001, 1'b0};
    vt[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1'b1};
    vt[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1'b1};
    vt[5]  = '{32'h7FC00000, 32'h40000000, 32'h7FC00000, 5'b10000, 1'b1};
    vt[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 1'b0};
    vt[7]  = '{32'h00800000, 32'h40800000, 32'h00000000, 5'b00011, 1'b0};
    vt[8]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, 1'b1};
    vt[9]  = '{32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000, 1'b1};
    vt[10] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 1'b1};
    vt[11] = '{32'hC0000000, 32'h00000000, 32'hFF800000, 5'b01000, 1'b1};
    vt[12] = '{32'h00000000, 32'hC0A00000, 32'h80000000, 5'b00000, 1'b1};
    vt[13] = '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 5'b00000, 1'b0};
    vt[14] = '{32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 1'b1};
    vt[15] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 5'b01000, 1'b1};
    vt[16] = '{32'h3FFFFFFF, 32'h3F800000, 32'h3FFFFFFF, 5'b00000, 1'b0};

    // reset values while rst held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 6.0/3.0 with core operand check
    do_op(32'h40C00000, 32'h40400000, 0, r, f, ns, acc, ok);
    chk("t1_ok", ok, 1);
    chk("t1_result", r, 32'h40000000);
    chk("t1_flags", f, 0);
    chk("t1_starts", ns, 1);
    chk("t1_div_a", last_div_a, 32'hC0000000);
    chk("t1_div_b", last_div_b, 32'hC0000000);

    // directed table
    for (int i = 0; i < 17; i++) begin
      do_op(vt[i].a, vt[i].b, i % 3, r, f, ns, acc, ok);
      chk($sformatf("vec%0d_ok", i), ok, 1);
      chk($sformatf("vec%0d_result", i), r, vt[i].res);
      chk($sformatf("vec%0d_flags", i), f, vt[i].flg);
      chk($sformatf("vec%0d_starts", i), ns, vt[i].spec ? 0 : 1);
      chk($sformatf("vec%0d_latency", i), acc, vt[i].spec ? 1 : last_lat + 4);
    end

    // backpressure: stall consumer for 10 cycles on 1.0/3.0
    a_fp = 32'h3F800000; b_fp = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin : bp_wait
      int cnt = 0;
      while (!out_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
    end
    chk("bp_valid", out_valid, 1);
    s0 = starts;
    for (int c = 0; c < 10; c++) begin
      chk("bp_result", result, 32'h3EAAAAAB);
      chk("bp_flags", flags, 5'b00001);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    chk("bp_no_start", starts - s0, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // reset asserted while waiting on the core
    force_lat = 30;
    a_fp = 32'h40C00000; b_fp = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("wait_in_ready", in_ready, 0);
    chk("wait_div_start", div_start, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_div_start", div_start, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", flags, 0);
    chk("abort_div_a", div_a, 0);
    chk("abort_div_b", div_b, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    force_lat = -1;
    do_op(32'h40C00000, 32'h40400000, 0, r, f, ns, acc, ok);
    chk("post_rst_ok", ok, 1);
    chk("post_rst_result", r, 32'h40000000);
    chk("post_rst_flags", f, 0);
    chk("post_rst_starts", ns, 1);

    // random operands against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      ref_div(ra, rb, er, ef, sp);
      do_op(ra, rb, int'($urandom_range(0, 2)), r, f, ns, acc, ok);
      chk($sformatf("rnd%0d_ok", n), ok, 1);
      chk($sformatf("rnd%0d_result a=%h b=%h", n, ra, rb), r, er);
      chk($sformatf("rnd%0d_flags a=%h b=%h", n, ra, rb), f, ef);
      chk($sformatf("rnd%0d_starts", n), ns, sp ? 0 : 1);
      chk($sformatf("rnd%0d_latency", n), acc, sp ? 1 : last_lat + 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
